// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
// States, bus field widths and the well-known slave addresses.
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] SLAVE_A = 7'h50;
  localparam logic [ADDR_W-1:0] SLAVE_B = 7'h51;

  typedef enum int unsigned {
    IDLE,
    ARB,
    XFER,
    ACK_LO,
    FINISH,
    GAP
  } state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Signal bundle between the arbiter and the shared I2C byte master.
// The master modport is the arbiter side; slave is the I2C engine side.
interface i2c_txn_arbiter_if;
  import i2c_arb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              m_rw;
  logic [DATA_W-1:0] m_tx_data;
  logic              m_enable;
  logic              m_restart;
  logic              m_ack;
  logic              m_ready;
  logic [DATA_W-1:0] m_rx_data;

  modport master (
    output address, m_rw, m_tx_data,
    output m_enable, m_restart,
    input  m_ack, m_ready, m_rx_data
  );

  modport slave (
    input  address, m_rw, m_tx_data,
    input  m_enable, m_restart,
    output m_ack, m_ready, m_rx_data
  );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after pointer.
// Produces both a one-hot winner and its binary index.
module rr_arbiter #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  output logic [N-1:0] winner,
  output logic [W-1:0] index
);

  logic found;
  int   j;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    j      = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(pointer) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        index     = W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one single-byte I2C master between NUM_REQ requesters.
// Round-robin grant, idle gap between transfers, per-transfer timeout.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int IDLE_GAP = 15,
  parameter int TIMEOUT  = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  i2c_txn_arbiter_if.master         bus
);

  localparam int PW   = $clog2(NUM_REQ);
  localparam int CMAX = (TIMEOUT > IDLE_GAP) ? TIMEOUT : IDLE_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  state_t            state, state_n;
  logic [PW-1:0]     ptr, win_idx;
  logic [NUM_REQ-1:0] win;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              enable;
  logic              busy, timeout, finish_ok;
  logic              gap_end, any_req;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req),
    .pointer (ptr),
    .winner  (win),
    .index   (win_idx)
  );

  assign any_req   = |req;
  assign busy      = state inside {XFER, ACK_LO, FINISH};
  assign timeout   = busy && (cnt == CW'(TIMEOUT - 1));
  assign finish_ok = (state == FINISH) && bus.m_ready;
  assign gap_end   = cnt == CW'(IDLE_GAP - 1);

  assign bus.address   = addr_q;
  assign bus.m_rw      = rw_q;
  assign bus.m_tx_data = wdata_q;
  assign bus.m_enable  = enable;
  assign bus.m_restart = 1'b0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Timeout has priority over every other exit of the busy states.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = ARB;
      ARB:     state_n = XFER;
      XFER: begin
        if (timeout)          state_n = GAP;
        else if (bus.m_ack)   state_n = ACK_LO;
      end
      ACK_LO: begin
        if (timeout)          state_n = GAP;
        else if (!bus.m_ack)  state_n = FINISH;
      end
      FINISH:  if (timeout || bus.m_ready) state_n = GAP;
      GAP:     if (gap_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    enable = 1'b0;
    unique case (state)
      XFER, ACK_LO: enable = 1'b1;
      default:      enable = 1'b0;
    endcase
  end

  // The pick is registered on ARB entry so grant is high throughout ARB;
  // the counter also starts there so timeout is measured from grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            grant   <= win;
            ptr     <= PW'(wrap_inc(int'(win_idx), NUM_REQ));
            addr_q  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            rw_q    <= req_rw[win_idx];
            cnt     <= '0;
          end
        end
        ARB: cnt <= cnt + CW'(1);
        XFER, ACK_LO, FINISH: begin
          if (timeout || finish_ok) begin
            done  <= grant;
            grant <= '0;
            err   <= timeout;
            cnt   <= '0;
            if (!timeout && rw_q) rdata <= bus.m_rx_data;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP:     cnt <= gap_end ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural I2C master.
// Expected completions are queued at request time and popped on done.
module tb_i2c_txn_arbiter;
  import i2c_arb_pkg::*;

  localparam int N    = 2;
  localparam int GAPC = 15;
  localparam int TO   = 4096;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rw, grant, done;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_wdata;
  logic           err;
  logic [7:0]     rdata;

  i2c_txn_arbiter_if bus ();

  typedef struct {
    int         idx;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wd;
    logic       er;
    logic [7:0] rd;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   now_cyc = 0;
  bit   model_on;
  bit   en_low_at_ready;

  i2c_txn_arbiter #(
    .NUM_REQ  (N),
    .IDLE_GAP (GAPC),
    .TIMEOUT  (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .bus       (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) now_cyc <= now_cyc + 1;

  // Behavioural byte master: ack pulse, then ready once enable drops.
  initial begin
    bus.m_ack = 1'b0;
    bus.m_ready = 1'b1;
    en_low_at_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (model_on && bus.m_enable && bus.m_ready) begin
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clock);
        bus.m_ack = 1'b1;
        repeat (2) @(negedge clock);
        bus.m_ack = 1'b0;
        for (int i = 0; i < 20 && bus.m_enable; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        en_low_at_ready = !bus.m_enable;
        bus.m_ready = 1'b1;
      end
    end
  end

  // 0: enable high, 1: any done, 2: any grant, 3: enable low
  task automatic wait_for(input int which, input int limit, output int cyc);
    bit hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < limit) begin
      @(negedge clock);
      cyc++;
      case (which)
        0:       hit = bus.m_enable;
        1:       hit = |done;
        2:       hit = |grant;
        default: hit = !bus.m_enable;
      endcase
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL wait_%0d: event absent after %0d cycles, required within bound",
               which, cyc);
    end
  endtask

  task automatic set_req(input int k, input bit on, input bit rw,
                         input logic [6:0] a, input logic [7:0] d);
    req[k] = on;
    req_rw[k] = rw;
    req_addr[7*k +: 7] = a;
    req_wdata[8*k +: 8] = d;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clock);
    n_chk++;
    if ({grant, done, err, rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_host: got %b %b %b %h, required all 0",
               grant, done, err, rdata);
    end
    n_chk++;
    if ({bus.address, bus.m_rw, bus.m_tx_data, bus.m_enable, bus.m_restart} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h %b %h %b %b, required all 0", bus.address,
               bus.m_rw, bus.m_tx_data, bus.m_enable, bus.m_restart);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++;
    if ({grant, bus.m_enable} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got grant %b en %b, required 0 0",
               grant, bus.m_enable);
    end
  endtask

  task automatic test_single_write;
    exp_t e;
    int   c;
    set_req(0, 1'b1, 1'b0, SLAVE_A, 8'hFE);
    q.push_back('{0, SLAVE_A, 1'b0, 8'hFE, 1'b0, 8'h00});
    wait_for(0, 20, c);
    n_chk++;
    if (c !== 2) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d cycles, required 2", c);
    end
    n_chk++;
    if ({bus.address, bus.m_rw, bus.m_tx_data, grant} !==
        {q[0].addr, q[0].rw, q[0].wd, 2'b01}) begin
      n_fail++;
      $display("FAIL wr_bus: got a=%h rw=%b d=%h g=%b, required %h %b %h 01",
               bus.address, bus.m_rw, bus.m_tx_data, grant,
               q[0].addr, q[0].rw, q[0].wd);
    end
    wait_for(1, 100, c);
    e = q.pop_front();
    n_chk++;
    if ({done, err, rdata, grant} !== {2'(1 << e.idx), e.er, e.rd, 2'b00}) begin
      n_fail++;
      $display("FAIL wr_done: got d=%b e=%b r=%h g=%b, required %b %b %h 00",
               done, err, rdata, grant, 2'(1 << e.idx), e.er, e.rd);
    end
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic test_single_read;
    exp_t e;
    int   c;
    bus.m_rx_data = 8'hCC;
    set_req(1, 1'b1, 1'b1, SLAVE_B, 8'h00);
    q.push_back('{1, SLAVE_B, 1'b1, 8'h00, 1'b0, 8'hCC});
    wait_for(0, 20, c);
    n_chk++;
    if ({bus.address, bus.m_rw, grant} !== {q[0].addr, q[0].rw, 2'b10}) begin
      n_fail++;
      $display("FAIL rd_bus: got a=%h rw=%b g=%b, required %h %b 10",
               bus.address, bus.m_rw, grant, q[0].addr, q[0].rw);
    end
    wait_for(1, 100, c);
    e = q.pop_front();
    n_chk++;
    if ({done, err, rdata} !== {2'(1 << e.idx), e.er, e.rd}) begin
      n_fail++;
      $display("FAIL rd_done: got d=%b e=%b r=%h, required %b %b %h",
               done, err, rdata, 2'(1 << e.idx), e.er, e.rd);
    end
    n_chk++;
    if (en_low_at_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_en_before_ready: got en_low %b, required 1",
               en_low_at_ready);
    end
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic test_contention;
    exp_t e;
    int   c;
    bus.m_rx_data = 8'h3C;
    set_req(0, 1'b1, 1'b0, SLAVE_A, 8'hA5);
    set_req(1, 1'b1, 1'b1, SLAVE_B, 8'h00);
    q.push_back('{0, SLAVE_A, 1'b0, 8'hA5, 1'b0, 8'hCC});
    q.push_back('{1, SLAVE_B, 1'b1, 8'h00, 1'b0, 8'h3C});
    q.push_back('{0, SLAVE_A, 1'b0, 8'hA5, 1'b0, 8'h3C});
    q.push_back('{1, SLAVE_B, 1'b1, 8'h00, 1'b0, 8'h3C});
    for (int t = 0; t < 4; t++) begin
      wait_for(2, 60, c);
      n_chk++;
      if (grant !== 2'(1 << q[0].idx)) begin
        n_fail++;
        $display("FAIL ct_grant_%0d: got %b, required %b", t, grant,
                 2'(1 << q[0].idx));
      end
      if (t > 0) begin
        n_chk++;
        if (c !== GAPC + 1) begin
          n_fail++;
          $display("FAIL ct_gap_%0d: got %0d cycles done->grant, required %0d",
                   t, c, GAPC + 1);
        end
      end
      wait_for(1, 100, c);
      e = q.pop_front();
      n_chk++;
      if ({done, err, rdata} !== {2'(1 << e.idx), e.er, e.rd}) begin
        n_fail++;
        $display("FAIL ct_done_%0d: got d=%b e=%b r=%h, required %b %b %h",
                 t, done, err, rdata, 2'(1 << e.idx), e.er, e.rd);
      end
    end
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic test_timeout;
    exp_t e;
    int   c;
    model_on = 1'b0;
    set_req(0, 1'b1, 1'b1, SLAVE_A, 8'h00);
    q.push_back('{0, SLAVE_A, 1'b1, 8'h00, 1'b1, 8'h3C});
    wait_for(2, 40, c);
    wait_for(1, TO + 20, c);
    e = q.pop_front();
    n_chk++;
    if (c !== TO) begin
      n_fail++;
      $display("FAIL to_latency: got %0d cycles grant->done, required %0d", c, TO);
    end
    n_chk++;
    if ({done, err, rdata, bus.m_enable} !== {2'(1 << e.idx), e.er, e.rd, 1'b0}) begin
      n_fail++;
      $display("FAIL to_done: got d=%b e=%b r=%h en=%b, required %b %b %h 0",
               done, err, rdata, bus.m_enable, 2'(1 << e.idx), e.er, e.rd);
    end
    set_req(0, 1'b0, 1'b0, 7'h00, 8'h00);
    @(negedge clock);
    n_chk++;
    if ({done, err, bus.m_enable} !== 4'b0010) begin
      n_fail++;
      $display("FAIL to_hold: got d=%b e=%b en=%b, required 00 1 0",
               done, err, bus.m_enable);
    end
    model_on = 1'b1;
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   c, t0;
    set_req(1, 1'b1, 1'b0, SLAVE_B, 8'h42);
    q.push_back('{1, SLAVE_B, 1'b0, 8'h42, 1'b0, 8'h3C});
    q.push_back('{1, SLAVE_B, 1'b0, 8'h42, 1'b0, 8'h3C});
    wait_for(0, 60, c);
    wait_for(3, 40, c);
    t0 = now_cyc;
    for (int t = 0; t < 2; t++) begin
      wait_for(1, 100, c);
      e = q.pop_front();
      n_chk++;
      if ({done, err, rdata} !== {2'(1 << e.idx), e.er, e.rd}) begin
        n_fail++;
        $display("FAIL b2b_done_%0d: got d=%b e=%b r=%h, required %b %b %h",
                 t, done, err, rdata, 2'(1 << e.idx), e.er, e.rd);
      end
      if (t == 0) begin
        wait_for(0, 60, c);
        n_chk++;
        if (now_cyc - t0 < GAPC) begin
          n_fail++;
          $display("FAIL b2b_idle: got %0d low cycles, required >= %0d",
                   now_cyc - t0, GAPC);
        end
      end
    end
    set_req(1, 1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   c;
    model_on = 1'b0;
    set_req(0, 1'b1, 1'b0, SLAVE_B, 8'h11);
    wait_for(0, 60, c);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({grant, done, err, rdata, bus.address, bus.m_rw, bus.m_tx_data,
         bus.m_enable} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got g=%b e=%b r=%h a=%h d=%h en=%b, required 0",
               grant, err, rdata, bus.address, bus.m_tx_data, bus.m_enable);
    end
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    model_on = 1'b1;
    bus.m_rx_data = 8'h77;
    set_req(0, 1'b1, 1'b0, SLAVE_A, 8'h5A);
    set_req(1, 1'b1, 1'b1, SLAVE_B, 8'h00);
    q.push_back('{0, SLAVE_A, 1'b0, 8'h5A, 1'b0, 8'h00});
    q.push_back('{1, SLAVE_B, 1'b1, 8'h00, 1'b0, 8'h77});
    for (int t = 0; t < 2; t++) begin
      wait_for(2, 60, c);
      n_chk++;
      if ({grant, bus.m_tx_data} !== {2'(1 << q[0].idx), q[0].wd}) begin
        n_fail++;
        $display("FAIL rm_grant_%0d: got g=%b d=%h, required %b %h", t,
                 grant, bus.m_tx_data, 2'(1 << q[0].idx), q[0].wd);
      end
      wait_for(1, 100, c);
      e = q.pop_front();
      n_chk++;
      if ({done, err, rdata} !== {2'(1 << e.idx), e.er, e.rd}) begin
        n_fail++;
        $display("FAIL rm_done_%0d: got d=%b e=%b r=%h, required %b %b %h",
                 t, done, err, rdata, 2'(1 << e.idx), e.er, e.rd);
      end
      set_req(e.idx, 1'b0, 1'b0, 7'h00, 8'h00);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    model_on = 1'b1;
    bus.m_rx_data = 8'h00;
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    repeat (GAPC + 4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
